// File: rtl/asca16_pkg.sv
// asca16_pkg -- shared definitions for the RAM arbiter slice.
//   arb_state_t : arbiter FSM state; each value names the owner of the
//                 previous cycle (IDLE = nobody, CORE, DBG, LOCK = locked dbg).
//   DEF_AW/DW   : default RAM address / data widths.
package asca16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2,
        LOCK = 2'd3
    } arb_state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

endpackage

// File: rtl/ram_arb_cnt.sv
// ram_arb_cnt -- saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear to zero (wins over inc)
//   inc        : increment by one, holding at MAX
//   cnt        : registered count
module ram_arb_cnt #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Count register: reset/clear to zero, otherwise saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter -- arbitrates a CPU core port and a debug/loader port onto one
// single-port synchronous RAM (1-cycle read latency).
//   clk, reset                              : clock, synchronous active-high reset
//   core_req/wen/addr/wdata                 : core access request
//   core_gnt, core_stall, core_rvalid       : core grant, stall, read return
//   dbg_req/lock/wen/addr/wdata             : debug access request (lock = burst)
//   dbg_gnt, dbg_rvalid                     : debug grant, read return
//   rdata                                   : read data for both ports (= ram_out)
//   ram_cen/wen/addr/data, ram_out          : RAM macro interface
// Build option: RAM_ARB_STARVE_GUARD_EN adds the debug starvation guard; without
// it the core has strict priority outside a locked debug burst.
module ram_arbiter
    import asca16_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_wen,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_lock,
    input  logic          dbg_wen,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_out
);

    // One counter width wide enough for either limit.
    localparam int CW = $clog2(((LOCK_MAX > STARVE_LIMIT) ? LOCK_MAX : STARVE_LIMIT) + 1);
    localparam logic [CW-1:0] LOCK_MAX_V = CW'(LOCK_MAX);

    arb_state_t    state_r;
    arb_state_t    state_nxt_s;
    logic          core_gnt_s;
    logic          dbg_gnt_s;
    logic [CW-1:0] lock_cnt_s;
    logic          lock_hold_s;
    logic          lock_done_s;
    logic          starve_hit_s;
    logic [AW-1:0] addr_hold_r;
    logic          core_rvalid_r;
    logic          dbg_rvalid_r;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam logic [CW-1:0] STARVE_MAX_V = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt_s;

    ram_arb_cnt #(.MAX(STARVE_LIMIT), .W(CW)) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (dbg_gnt_s | ~dbg_req),
        .inc   (dbg_req & ~dbg_gnt_s),
        .cnt   (starve_cnt_s)
    );

    assign starve_hit_s = dbg_req && (starve_cnt_s == STARVE_MAX_V);
`else
    assign starve_hit_s = 1'b0;
`endif

    // Lock counter only runs while the next owner is a locked debug burst,
    // so it is zero whenever the FSM is outside LOCK.
    ram_arb_cnt #(.MAX(LOCK_MAX), .W(CW)) u_lock_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_nxt_s != LOCK),
        .inc   (state_nxt_s == LOCK),
        .cnt   (lock_cnt_s)
    );

    assign lock_hold_s = (state_r == LOCK) && dbg_req && dbg_lock && (lock_cnt_s < LOCK_MAX_V);
    assign lock_done_s = (lock_cnt_s == LOCK_MAX_V);

    // Grant decision and next-state; a burst that used up its budget drops to
    // DBG so the lock counter clears and the burst has to re-enter LOCK.
    always_comb begin
        core_gnt_s  = 1'b0;
        dbg_gnt_s   = 1'b0;
        state_nxt_s = IDLE;
        if (reset) begin
            core_gnt_s = 1'b0;
            dbg_gnt_s  = 1'b0;
        end else if (lock_hold_s || starve_hit_s) begin
            dbg_gnt_s = 1'b1;
        end else if (core_req) begin
            core_gnt_s = 1'b1;
        end else if (dbg_req) begin
            dbg_gnt_s = 1'b1;
        end else begin
            core_gnt_s = 1'b0;
            dbg_gnt_s  = 1'b0;
        end

        if (core_gnt_s) begin
            state_nxt_s = CORE;
        end else if (dbg_gnt_s) begin
            if (dbg_lock && !lock_done_s) begin
                state_nxt_s = LOCK;
            end else begin
                state_nxt_s = DBG;
            end
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // RAM request mux; with no grant the address parks on its last value.
    always_comb begin
        ram_cen  = core_gnt_s | dbg_gnt_s;
        ram_wen  = 1'b0;
        ram_addr = addr_hold_r;
        ram_data = {DW{1'b0}};
        if (core_gnt_s) begin
            ram_wen  = core_wen;
            ram_addr = core_addr;
            ram_data = core_wdata;
        end else if (dbg_gnt_s) begin
            ram_wen  = dbg_wen;
            ram_addr = dbg_addr;
            ram_data = dbg_wdata;
        end else begin
            ram_wen  = 1'b0;
            ram_addr = addr_hold_r;
            ram_data = {DW{1'b0}};
        end
    end

    // Parked address register, follows every granted access.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_r <= {AW{1'b0}};
        end else if (ram_cen) begin
            addr_hold_r <= ram_addr;
        end else begin
            addr_hold_r <= addr_hold_r;
        end
    end

    // Read-return flags, one cycle after a read grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_rvalid_r <= 1'b0;
            dbg_rvalid_r  <= 1'b0;
        end else begin
            core_rvalid_r <= core_gnt_s & ~core_wen;
            dbg_rvalid_r  <= dbg_gnt_s & ~dbg_wen;
        end
    end

    assign core_gnt    = core_gnt_s;
    assign dbg_gnt     = dbg_gnt_s;
    assign core_stall  = core_req & ~core_gnt_s;
    // A read in flight when reset arrives must never be reported.
    assign core_rvalid = core_rvalid_r & ~reset;
    assign dbg_rvalid  = dbg_rvalid_r & ~reset;
    assign rdata       = ram_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- randomized and directed bench for ram_arbiter with a
// transaction-level reference model (wait/burst counters and a memory image).
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int STARVE_LIMIT = 8;
    localparam int LOCK_MAX = 16;
`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
    localparam int EXP_FIRST_DBG = 9;
    localparam int EXP_RESUME = 25;
`else
    localparam bit GUARD = 1'b0;
    localparam int EXP_FIRST_DBG = 0;
    localparam int EXP_RESUME = 0;
`endif

    logic clk, reset;
    logic core_req, core_wen, core_gnt, core_stall, core_rvalid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic dbg_req, dbg_lock, dbg_wen, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] rdata;
    logic ram_cen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_out;

    ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM attached to the DUT.
    logic [DW-1:0] ram_mem [0:65535];
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_data;
            else         ram_out <= ram_mem[ram_addr];
        end
    end

    // Reference model state.
    logic [DW-1:0] m_mem [0:65535];
    int            m_wait;      // consecutive cycles dbg has waited
    int            m_burst;     // consecutive locked dbg grants in current burst
    logic [AW-1:0] m_addr;
    logic          m_core_rv, m_dbg_rv;
    logic [DW-1:0] m_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic obs_core, obs_dbg, obs_stall, obs_drv, obs_cen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run_cycle(input logic rst,
                             input logic creq, input logic cwen, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                             input logic dreq, input logic dlock, input logic dwen, input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
        logic e_core, e_dbg, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        @(negedge clk);
        reset = rst;
        core_req = creq; core_wen = cwen; core_addr = caddr; core_wdata = cwd;
        dbg_req = dreq; dbg_lock = dlock; dbg_wen = dwen; dbg_addr = daddr; dbg_wdata = dwd;
        #1;
        obs_core = core_gnt; obs_dbg = dbg_gnt; obs_stall = core_stall;
        obs_drv = dbg_rvalid; obs_cen = ram_cen;
        // read returns from the previous cycle
        check_val("core_rvalid", core_rvalid, m_core_rv & ~rst);
        check_val("dbg_rvalid", dbg_rvalid, m_dbg_rv & ~rst);
        if ((m_core_rv | m_dbg_rv) & ~rst) check_val("rdata", rdata, m_rdata);
        // arbitration
        e_core = 1'b0; e_dbg = 1'b0;
        if (!rst) begin
            if (m_burst > 0 && m_burst < LOCK_MAX && dreq && dlock) e_dbg = 1'b1;
            else if (GUARD && m_wait >= STARVE_LIMIT && dreq) e_dbg = 1'b1;
            else if (creq) e_core = 1'b1;
            else if (dreq) e_dbg = 1'b1;
        end
        e_wen  = e_core ? cwen : (e_dbg ? dwen : 1'b0);
        e_addr = e_core ? caddr : (e_dbg ? daddr : m_addr);
        e_data = e_core ? cwd : (e_dbg ? dwd : {DW{1'b0}});
        check_val("core_gnt", core_gnt, e_core);
        check_val("dbg_gnt", dbg_gnt, e_dbg);
        check_val("core_stall", core_stall, creq & ~e_core);
        check_val("ram_cen", ram_cen, e_core | e_dbg);
        check_val("ram_wen", ram_wen, e_wen);
        check_val("ram_addr", ram_addr, e_addr);
        check_val("ram_data", ram_data, e_data);
        // advance model to the state after this clock edge
        if (rst) begin
            m_wait = 0; m_burst = 0; m_addr = '0; m_core_rv = 1'b0; m_dbg_rv = 1'b0;
        end else begin
            if (e_core | e_dbg) begin
                m_addr = e_addr;
                if (e_wen) m_mem[e_addr] = e_data;
                else m_rdata = m_mem[e_addr];
            end
            m_core_rv = e_core & ~cwen;
            m_dbg_rv  = e_dbg & ~dwen;
            if (e_dbg && dlock) m_burst = (m_burst == LOCK_MAX) ? 0 : m_burst + 1;
            else m_burst = 0;
            if (dreq && !e_dbg) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : STARVE_LIMIT;
            else m_wait = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    int first_dbg, burst_len, resume, core_after;
    logic burst_open;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = '0;
            m_mem[i] = '0;
        end
        ram_out = '0;
        m_wait = 0; m_burst = 0; m_addr = '0; m_core_rv = 1'b0; m_dbg_rv = 1'b0; m_rdata = '0;
        reset = 1'b1;
        core_req = 1'b0; core_wen = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req = 1'b0; dbg_lock = 1'b0; dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        // checked reset cycles
        for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b1, 1'b0, 16'h1234, '0, 1'b1, 1'b1, 1'b0, 16'h4321, '0);
        idle(2);
        check_val("reset_addr", ram_addr, 16'h0000);

        // core write then read back
        run_cycle(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0, '0);
        check_val("wr_gnt", obs_core, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0);
        check_val("rd_gnt", obs_core, 1'b1);
        idle(1);
        check_val("beef_rvalid", core_rvalid, 1'b1);
        check_val("beef_data", rdata, 16'hBEEF);

        // idle: ram parked
        idle(5);
        check_val("idle_addr", ram_addr, 16'h0010);

        // both requesting continuously
        first_dbg = 0;
        for (int i = 1; i <= 20; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, 1'b0, AW'(16'h0200 + i), '0);
            if (obs_dbg && first_dbg == 0) first_dbg = i;
        end
        check_val("first_dbg", first_dbg, EXP_FIRST_DBG);
        idle(3);

        // locked debug burst against a busy core
        burst_len = 0; burst_open = 1'b1; resume = 0; core_after = 0;
        for (int i = 1; i <= 30; i++) begin
            run_cycle(1'b0, (i > 1), 1'b0, 16'h0020, '0, 1'b1, 1'b1, 1'b0, AW'(16'h0100 + i), '0);
            if (burst_open && obs_dbg) burst_len++;
            else if (burst_open) begin
                burst_open = 1'b0;
                core_after = obs_core;
            end
            else if (obs_dbg && resume == 0) resume = i;
        end
        check_val("lock_burst", burst_len, LOCK_MAX);
        check_val("core_after_lock", core_after, 1'b1);
        check_val("dbg_resume", resume, EXP_RESUME);
        idle(3);

        // reset right after a debug read grant
        run_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 16'h0300, '0);
        check_val("pre_rst_dbg", obs_dbg, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b1, 1'b0, 16'h0301, '0);
        check_val("rst_rvalid", obs_drv, 1'b0);
        check_val("rst_cen", obs_cen, 1'b0);
        idle(2);
        check_val("post_rst_rvalid", dbg_rvalid, 1'b0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            run_cycle(($urandom % 64) == 0,
                      ($urandom % 2) == 0, ($urandom % 3) == 0, AW'($urandom % 32), DW'($urandom),
                      ($urandom % 5) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
                      AW'($urandom % 32), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
